toy_imem_arbiter: RTL and testbench

Shares one instruction/data memory port between the core's fetch stage and the load/store unit. Round-robin arbitration with grant locking, in-order response routing through an order FIFO, and a fetch flush that silently drops responses belonging to a redirected fetch stream. Sits between the fetch stage / LSU and the single memory-bus master port.

---
 rtl/toy_imem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_toy_imem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_imem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and LSU, in-order response routing.
// Optional perf counters are compiled in when TOY_IMEM_ARB_PERF_EN is defined.
module toy_imem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int OST_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      f_req_vld,
    output logic                      f_req_rdy,
    input  logic [ADDR_WIDTH-1:0]     f_req_addr,
    output logic                      f_ack_vld,
    input  logic                      f_ack_rdy,
    output logic [DATA_WIDTH-1:0]     f_ack_data,
    input  logic                      f_flush,
    input  logic                      d_req_vld,
    output logic                      d_req_rdy,
    input  logic [ADDR_WIDTH-1:0]     d_req_addr,
    input  logic                      d_req_wr,
    input  logic [DATA_WIDTH-1:0]     d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_req_strb,
    output logic                      d_ack_vld,
    input  logic                      d_ack_rdy,
    output logic [DATA_WIDTH-1:0]     d_ack_data,
    output logic                      m_req_vld,
    input  logic                      m_req_rdy,
    output logic [ADDR_WIDTH-1:0]     m_req_addr,
    output logic                      m_req_wr,
    output logic [DATA_WIDTH-1:0]     m_req_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_req_strb,
    input  logic                      m_ack_vld,
    output logic                      m_ack_rdy,
    input  logic [DATA_WIDTH-1:0]     m_ack_data,
    output logic [$clog2(OST_DEPTH):0] ost_cnt,
    output logic                      err_unexp_ack,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_drop_cnt
);

    localparam int PW = $clog2(OST_DEPTH);
    localparam int CW = PW + 1;
    localparam logic SRC_F = 1'b0;
    localparam logic SRC_D = 1'b1;

    logic [OST_DEPTH-1:0] src_q, src_d;
    logic [OST_DEPTH-1:0] stale_q, stale_d;
    logic [PW-1:0]        wr_q, rd_q;
    logic [CW-1:0]        cnt_q;
    logic                 last_gnt_q, last_gnt_d;
    logic                 lock_q, lock_d;
    logic                 lock_src_q, lock_src_d;
    logic                 err_q;

    logic fifo_full, fifo_empty;
    logic lock_use, gnt, accept, push, pop;
    logic head_src, head_stale;

    assign fifo_full  = (cnt_q == CW'(OST_DEPTH));
    assign fifo_empty = (cnt_q == '0);

    // A held grant only survives while its owner keeps requesting.
    assign lock_use = lock_q & (lock_src_q ? d_req_vld : f_req_vld);

    always_comb begin
        gnt = SRC_F;
        if (lock_use) begin
            gnt = lock_src_q;
        end else if (f_req_vld && d_req_vld) begin
            gnt = ~last_gnt_q;
        end else begin
            gnt = d_req_vld;
        end
    end

    assign m_req_vld   = (f_req_vld | d_req_vld) & ~fifo_full;
    assign accept      = m_req_vld & m_req_rdy;
    assign push        = accept;
    assign f_req_rdy   = f_req_vld & (gnt == SRC_F) & m_req_rdy & ~fifo_full;
    assign d_req_rdy   = d_req_vld & (gnt == SRC_D) & m_req_rdy & ~fifo_full;
    assign m_req_addr  = gnt ? d_req_addr : f_req_addr;
    assign m_req_wr    = gnt & d_req_wr;
    assign m_req_wdata = gnt ? d_req_wdata : '0;
    assign m_req_strb  = gnt ? d_req_strb : '1;

    always_comb begin
        last_gnt_d = accept ? gnt : last_gnt_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (m_req_vld && !m_req_rdy) begin
            lock_d     = 1'b1;
            lock_src_d = gnt;
        end else if (!lock_use) begin
            lock_d = 1'b0;
        end
    end

    assign head_src   = src_q[rd_q];
    assign head_stale = stale_q[rd_q];

    always_comb begin
        f_ack_vld = 1'b0;
        d_ack_vld = 1'b0;
        m_ack_rdy = 1'b1;
        if (!fifo_empty && !head_stale) begin
            if (head_src == SRC_D) begin
                d_ack_vld = m_ack_vld;
                m_ack_rdy = d_ack_rdy;
            end else begin
                f_ack_vld = m_ack_vld;
                m_ack_rdy = f_ack_rdy;
            end
        end
    end

    assign f_ack_data = m_ack_data;
    assign d_ack_data = m_ack_data;
    assign pop        = m_ack_vld & m_ack_rdy & ~fifo_empty;

    // Flush marks every fetch slot; a same-cycle push overwrites its slot clean.
    always_comb begin
        src_d   = src_q;
        stale_d = stale_q | ({OST_DEPTH{f_flush}} & ~src_q);
        if (push) begin
            src_d[wr_q]   = gnt;
            stale_d[wr_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= '0;
            stale_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            last_gnt_q <= SRC_F;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_F;
            err_q      <= 1'b0;
        end else begin
            src_q      <= src_d;
            stale_q    <= stale_d;
            last_gnt_q <= last_gnt_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            err_q      <= err_q | (m_ack_vld & fifo_empty);
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign ost_cnt       = cnt_q;
    assign err_unexp_ack = err_q;

`ifdef TOY_IMEM_ARB_PERF_EN
    logic [31:0] stall_q, drop_q;
    logic        stall_ev, drop_ev;

    assign stall_ev = (f_req_vld & ~(accept & (gnt == SRC_F)))
                    | (d_req_vld & ~(accept & (gnt == SRC_D)));
    assign drop_ev  = pop & head_stale;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            if (stall_ev && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (drop_ev && drop_q != '1)   drop_q  <= drop_q + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_drop_cnt  = drop_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_toy_imem_arbiter.sv
// Self-checking bench for toy_imem_arbiter: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_toy_imem_arbiter;

`ifdef TOY_IMEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req_vld, f_req_rdy;
    logic [31:0] f_req_addr;
    logic        f_ack_vld, f_ack_rdy;
    logic [31:0] f_ack_data;
    logic        f_flush;
    logic        d_req_vld, d_req_rdy;
    logic [31:0] d_req_addr;
    logic        d_req_wr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_strb;
    logic        d_ack_vld, d_ack_rdy;
    logic [31:0] d_ack_data;
    logic        m_req_vld, m_req_rdy;
    logic [31:0] m_req_addr;
    logic        m_req_wr;
    logic [31:0] m_req_wdata;
    logic [3:0]  m_req_strb;
    logic        m_ack_vld, m_ack_rdy;
    logic [31:0] m_ack_data;
    logic [2:0]  ost_cnt;
    logic        err_unexp_ack;
    logic [31:0] perf_stall_cnt, perf_drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    toy_imem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req_vld(f_req_vld), .f_req_rdy(f_req_rdy), .f_req_addr(f_req_addr),
        .f_ack_vld(f_ack_vld), .f_ack_rdy(f_ack_rdy), .f_ack_data(f_ack_data),
        .f_flush(f_flush),
        .d_req_vld(d_req_vld), .d_req_rdy(d_req_rdy), .d_req_addr(d_req_addr),
        .d_req_wr(d_req_wr), .d_req_wdata(d_req_wdata), .d_req_strb(d_req_strb),
        .d_ack_vld(d_ack_vld), .d_ack_rdy(d_ack_rdy), .d_ack_data(d_ack_data),
        .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
        .m_req_wr(m_req_wr), .m_req_wdata(m_req_wdata), .m_req_strb(m_req_strb),
        .m_ack_vld(m_ack_vld), .m_ack_rdy(m_ack_rdy), .m_ack_data(m_ack_data),
        .ost_cnt(ost_cnt), .err_unexp_ack(err_unexp_ack),
        .perf_stall_cnt(perf_stall_cnt), .perf_drop_cnt(perf_drop_cnt)
    );

    task automatic idle();
        f_req_vld = 0; f_req_addr = 0; f_ack_rdy = 0; f_flush = 0;
        d_req_vld = 0; d_req_addr = 0; d_req_wr = 0; d_req_wdata = 0;
        d_req_strb = 0; d_ack_rdy = 0; m_req_rdy = 0; m_ack_vld = 0;
        m_ack_data = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #1;
        n_cmp++; if (m_req_vld !== 1'b0) begin n_bad++; $display("FAIL rst_mvld got %b exp 0", m_req_vld); end
        n_cmp++; if ({f_ack_vld, d_ack_vld} !== 2'b00) begin n_bad++; $display("FAIL rst_ackvld got %b exp 00", {f_ack_vld, d_ack_vld}); end
        n_cmp++; if (ost_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_ost got %0d exp 0", ost_cnt); end
        n_cmp++; if (err_unexp_ack !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", err_unexp_ack); end
        n_cmp++; if ({perf_stall_cnt, perf_drop_cnt} !== 64'd0) begin n_bad++; $display("FAIL rst_perf got %h/%h exp 0", perf_stall_cnt, perf_drop_cnt); end
        do_reset();
    endtask

    task automatic test_alternate();
        logic [31:0] ea;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            f_req_vld = 1; d_req_vld = 1; m_req_rdy = 1;
            f_req_addr = 32'h8000_0000 + 32'(i * 4);
            d_req_addr = 32'h1000_0000 + 32'(i * 4);
            #1;
            ea = (i % 2 == 0) ? d_req_addr : f_req_addr;
            n_cmp++; if (m_req_vld !== (i < 4)) begin n_bad++; $display("FAIL alt_vld[%0d] got %b exp %b", i, m_req_vld, i < 4); end
            if (i < 4) begin
                n_cmp++; if (m_req_addr !== ea) begin n_bad++; $display("FAIL alt_addr[%0d] got %h exp %h", i, m_req_addr, ea); end
            end else begin
                n_cmp++; if ({f_req_rdy, d_req_rdy} !== 2'b00) begin n_bad++; $display("FAIL alt_full_rdy[%0d] got %b exp 00", i, {f_req_rdy, d_req_rdy}); end
            end
            n_cmp++; if (ost_cnt !== 3'((i < 4) ? i : 4)) begin n_bad++; $display("FAIL alt_ost[%0d] got %0d exp %0d", i, ost_cnt, (i < 4) ? i : 4); end
        end
        @(negedge clk);
        d_req_addr = 32'h1000_0100;
        m_ack_vld = 1; m_ack_data = 32'h55; f_ack_rdy = 1; d_ack_rdy = 1;
        #1;
        n_cmp++; if ({d_ack_vld, f_ack_vld, m_req_vld} !== 3'b100) begin n_bad++; $display("FAIL alt_pop_full got %b exp 100", {d_ack_vld, f_ack_vld, m_req_vld}); end
        @(negedge clk);
        m_ack_vld = 0;
        #1;
        n_cmp++; if (ost_cnt !== 3'd3) begin n_bad++; $display("FAIL alt_ost_after_pop got %0d exp 3", ost_cnt); end
        n_cmp++; if (m_req_vld !== 1'b1 || m_req_addr !== 32'h1000_0100) begin n_bad++; $display("FAIL alt_regrant got %b/%h exp 1/10000100", m_req_vld, m_req_addr); end
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            f_req_vld = 1; f_req_addr = 32'h8000_0040 + 32'(c * 4);
            d_req_vld = (c > 0); d_req_addr = 32'h1000_0040; d_req_wr = 1;
            d_req_wdata = 32'hdead_beef; d_req_strb = 4'h5;
            m_req_rdy = (c >= 3);
            #1;
            if (c < 4) begin
                n_cmp++; if (m_req_addr !== f_req_addr || m_req_wr !== 1'b0 || m_req_strb !== 4'hf) begin n_bad++; $display("FAIL lock_f[%0d] got %h/%b/%h exp %h/0/f", c, m_req_addr, m_req_wr, m_req_strb, f_req_addr); end
                n_cmp++; if ({f_req_rdy, d_req_rdy} !== {c == 3, 1'b0}) begin n_bad++; $display("FAIL lock_rdy[%0d] got %b exp %b0", c, {f_req_rdy, d_req_rdy}, c == 3); end
            end else begin
                n_cmp++; if (m_req_addr !== 32'h1000_0040 || m_req_wr !== 1'b1 || m_req_wdata !== 32'hdead_beef || m_req_strb !== 4'h5) begin n_bad++; $display("FAIL lock_d got %h/%b/%h/%h exp 10000040/1/deadbeef/5", m_req_addr, m_req_wr, m_req_wdata, m_req_strb); end
                n_cmp++; if ({f_req_rdy, d_req_rdy} !== 2'b01) begin n_bad++; $display("FAIL lock_drdy got %b exp 01", {f_req_rdy, d_req_rdy}); end
            end
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (ost_cnt !== 3'd2) begin n_bad++; $display("FAIL lock_ost got %0d exp 2", ost_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            f_req_vld = 1; m_req_rdy = 1;
            f_req_addr = (c < 3) ? 32'h8000_0000 + 32'(c * 4) : 32'h8000_0100;
            f_flush = (c == 3);
            #1;
            n_cmp++; if (f_req_rdy !== 1'b1) begin n_bad++; $display("FAIL flush_req[%0d] got %b exp 1", c, f_req_rdy); end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            m_ack_vld = 1; m_ack_data = 32'hA000_0000 + 32'(k);
            f_ack_rdy = (k == 3);
            #1;
            n_cmp++; if ({f_ack_vld, d_ack_vld, m_ack_rdy} !== {k == 3, 1'b0, 1'b1}) begin n_bad++; $display("FAIL flush_ack[%0d] got %b exp %b01", k, {f_ack_vld, d_ack_vld, m_ack_rdy}, k == 3); end
            if (k == 3) begin
                n_cmp++; if (f_ack_data !== 32'hA000_0003) begin n_bad++; $display("FAIL flush_data got %h exp a0000003", f_ack_data); end
            end
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (ost_cnt !== 3'd0) begin n_bad++; $display("FAIL flush_ost got %0d exp 0", ost_cnt); end
        n_cmp++; if (perf_drop_cnt !== (PERF ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL flush_drop got %0d exp %0d", perf_drop_cnt, PERF ? 3 : 0); end
    endtask

    task automatic test_in_order();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle();
            m_req_rdy = 1;
            f_req_vld = (c != 1); f_req_addr = 32'h8000_0200;
            d_req_vld = (c == 1); d_req_addr = 32'h1000_0200;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            idle();
            m_ack_vld = 1; m_ack_data = 32'h11; d_ack_rdy = 1;
            #1;
            n_cmp++; if ({f_ack_vld, d_ack_vld, m_ack_rdy} !== 3'b100) begin n_bad++; $display("FAIL order_wait[%0d] got %b exp 100", c, {f_ack_vld, d_ack_vld, m_ack_rdy}); end
            n_cmp++; if (ost_cnt !== 3'd3) begin n_bad++; $display("FAIL order_ost[%0d] got %0d exp 3", c, ost_cnt); end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m_ack_vld = 1; m_ack_data = 32'h20 + 32'(k);
            f_ack_rdy = 1; d_ack_rdy = 1;
            #1;
            n_cmp++; if ({f_ack_vld, d_ack_vld, m_ack_rdy} !== {k != 1, k == 1, 1'b1}) begin n_bad++; $display("FAIL order_drain[%0d] got %b exp %b%b1", k, {f_ack_vld, d_ack_vld, m_ack_rdy}, k != 1, k == 1); end
            n_cmp++; if ((k == 1 ? d_ack_data : f_ack_data) !== 32'h20 + 32'(k)) begin n_bad++; $display("FAIL order_data[%0d] got %h/%h exp %h", k, f_ack_data, d_ack_data, 32'h20 + k); end
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (ost_cnt !== 3'd0) begin n_bad++; $display("FAIL order_ost_end got %0d exp 0", ost_cnt); end
    endtask

    task automatic test_unexp_ack();
        do_reset();
        @(negedge clk);
        m_ack_vld = 1; m_ack_data = 32'h77; f_ack_rdy = 0; d_ack_rdy = 0;
        #1;
        n_cmp++; if ({m_ack_rdy, f_ack_vld, d_ack_vld, err_unexp_ack} !== 4'b1000) begin n_bad++; $display("FAIL unexp_cycle got %b exp 1000", {m_ack_rdy, f_ack_vld, d_ack_vld, err_unexp_ack}); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle();
            #1;
            n_cmp++; if (err_unexp_ack !== 1'b1) begin n_bad++; $display("FAIL unexp_sticky[%0d] got %b exp 1", c, err_unexp_ack); end
        end
        rst_n = 0;
        #1;
        n_cmp++; if (err_unexp_ack !== 1'b0) begin n_bad++; $display("FAIL unexp_clear got %b exp 0", err_unexp_ack); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            f_req_vld = 1; m_req_rdy = 1; f_req_addr = 32'h8000_0300 + 32'(c * 4);
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (ost_cnt !== 3'd2) begin n_bad++; $display("FAIL rmid_pre got %0d exp 2", ost_cnt); end
        rst_n = 0;
        #1;
        n_cmp++; if (ost_cnt !== 3'd0 || m_req_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_clr got %0d/%b exp 0/0", ost_cnt, m_req_vld); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        m_ack_vld = 1; f_ack_rdy = 1;
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (err_unexp_ack !== 1'b1) begin n_bad++; $display("FAIL rmid_err got %b exp 1", err_unexp_ack); end
    endtask

    typedef struct { bit d; bit stale; } ent_t;

    task automatic test_random();
        ent_t        q[$];
        bit          last_d, hold, hold_d, w, any, full, mvld, acc;
        bit          efa, eda, emr, pop;
        int unsigned stall_m, drop_m;
        logic [31:0] ea, ewd;
        logic [3:0]  es;
        do_reset();
        last_d = 0; hold = 0; hold_d = 0; stall_m = 0; drop_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            f_req_vld   = ($urandom_range(0, 99) < 55);
            d_req_vld   = ($urandom_range(0, 99) < 55);
            f_req_addr  = $urandom;
            d_req_addr  = $urandom;
            d_req_wr    = $urandom_range(0, 1);
            d_req_wdata = $urandom;
            d_req_strb  = 4'($urandom);
            m_req_rdy   = ($urandom_range(0, 99) < 65);
            f_flush     = ($urandom_range(0, 99) < 8);
            f_ack_rdy   = ($urandom_range(0, 99) < 70);
            d_ack_rdy   = ($urandom_range(0, 99) < 70);
            m_ack_vld   = (q.size() > 0) && ($urandom_range(0, 99) < 50);
            m_ack_data  = $urandom;
            #1;
            full = (q.size() == 4);
            any  = f_req_vld | d_req_vld;
            if (hold && (hold_d ? d_req_vld : f_req_vld)) w = hold_d;
            else if (f_req_vld && d_req_vld) w = !last_d;
            else w = d_req_vld;
            mvld = any && !full;
            acc  = mvld && m_req_rdy;
            efa = 0; eda = 0; emr = 1;
            if (q.size() > 0 && !q[0].stale) begin
                if (q[0].d) begin eda = m_ack_vld; emr = d_ack_rdy; end
                else begin efa = m_ack_vld; emr = f_ack_rdy; end
            end
            n_cmp++;
            if ({m_req_vld, f_req_rdy, d_req_rdy, f_ack_vld, d_ack_vld, m_ack_rdy} !==
                {mvld, acc && !w, acc && w, efa, eda, emr}) begin
                n_bad++;
                $display("FAIL rnd_hs[%0d] got %b exp %b", cyc,
                         {m_req_vld, f_req_rdy, d_req_rdy, f_ack_vld, d_ack_vld, m_ack_rdy},
                         {mvld, acc && !w, acc && w, efa, eda, emr});
            end
            if (mvld) begin
                ea  = w ? d_req_addr : f_req_addr;
                ewd = w ? d_req_wdata : 32'd0;
                es  = w ? d_req_strb : 4'hf;
                n_cmp++;
                if ({m_req_addr, m_req_wr, m_req_wdata, m_req_strb} !== {ea, w && d_req_wr, ewd, es}) begin
                    n_bad++;
                    $display("FAIL rnd_pay[%0d] got %h/%b/%h/%h exp %h/%b/%h/%h", cyc,
                             m_req_addr, m_req_wr, m_req_wdata, m_req_strb, ea, w && d_req_wr, ewd, es);
                end
            end
            if (efa || eda) begin
                n_cmp++;
                if ((efa ? f_ack_data : d_ack_data) !== m_ack_data) begin n_bad++; $display("FAIL rnd_data[%0d] got %h/%h exp %h", cyc, f_ack_data, d_ack_data, m_ack_data); end
            end
            n_cmp++;
            if (ost_cnt !== 3'(q.size()) || err_unexp_ack !== 1'b0) begin n_bad++; $display("FAIL rnd_ost[%0d] got %0d/%b exp %0d/0", cyc, ost_cnt, err_unexp_ack, q.size()); end
            n_cmp++;
            if (perf_stall_cnt !== (PERF ? stall_m : 0) || perf_drop_cnt !== (PERF ? drop_m : 0)) begin
                n_bad++;
                $display("FAIL rnd_perf[%0d] got %0d/%0d exp %0d/%0d", cyc, perf_stall_cnt, perf_drop_cnt, PERF ? stall_m : 0, PERF ? drop_m : 0);
            end
            pop = m_ack_vld && emr && (q.size() > 0);
            if (pop) begin
                if (q[0].stale) drop_m++;
                void'(q.pop_front());
            end
            if (f_flush) foreach (q[i]) if (!q[i].d) q[i].stale = 1;
            if (acc) q.push_back('{d: w, stale: 0});
            if ((f_req_vld && !(acc && !w)) || (d_req_vld && !(acc && w))) stall_m++;
            if (acc) begin
                hold = 0;
                last_d = w;
            end else if (mvld) begin
                hold = 1;
                hold_d = w;
            end else if (hold && !(hold_d ? d_req_vld : f_req_vld)) begin
                hold = 0;
            end
        end
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_alternate();
        test_lock();
        test_flush();
        test_in_order();
        test_unexp_ack();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
